// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int unsigned PC_W           = 32;
   localparam int unsigned WORD_IDX_W     = 7;
   localparam int unsigned IMEM_WORDS_DEF = 128;

   localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0]     NOP_INSTR    = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // IF/ID pipeline register payload
   typedef struct packed {
      logic [31:0]     instruction;
      logic [PC_W-1:0] pc_plus4;
      logic            valid;
   } ifid_t;

   // Force a byte address onto a word boundary
   function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_select.sv
// Next-PC / next-state selection and IF/ID update decode for the fetch sequencer.
module pc_next_select
   import fetch_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
   input  logic [PC_W-1:0] pc,
   input  fetch_state_e    state,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   output logic [PC_W-1:0] pc_nxt_c,
   output fetch_state_e    state_nxt_c,
   output logic            fetch_c,
   output logic            squash_c,
   output logic            drop_c
);

   localparam logic [PC_W-3:0] LAST_WORD = (PC_W-2)'(IMEM_WORDS - 1);

   logic            redirect;
   logic [PC_W-1:0] target;

   // Priority: redirect (branch over jump), then stall, then sequential fetch
   always_comb begin
      redirect    = branch_taken | jump;
      target      = align_word(branch_taken ? branch_target : jump_target);
      pc_nxt_c    = pc;
      state_nxt_c = state;
      fetch_c     = 1'b0;
      squash_c    = 1'b0;
      drop_c      = 1'b0;
      case (state)
         BOOT: state_nxt_c = RUN;
         RUN: begin
            if (redirect) begin
               pc_nxt_c = target;
               squash_c = 1'b1;
            end else if (!stall) begin
               fetch_c = 1'b1;
               // Last memory word: latch it, then park instead of wrapping
               if (pc[PC_W-1:2] == LAST_WORD) state_nxt_c = HALT;
               else                           pc_nxt_c    = pc + PC_W'(4);
            end
         end
         HALT: begin
            if (redirect) begin
               pc_nxt_c    = target;
               squash_c    = 1'b1;
               state_nxt_c = RUN;
            end else begin
               drop_c = 1'b1;
            end
         end
         default: state_nxt_c = BOOT;
      endcase
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC, IF/ID register, halt flag and fetch counter.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned     IMEM_WORDS = IMEM_WORDS_DEF
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Stall,
   input  logic            BranchTaken,
   input  logic [PC_W-1:0] BranchTarget,
   input  logic            Jump,
   input  logic [PC_W-1:0] JumpTarget,
   output logic [PC_W-1:0] ImemAddress,
   input  logic [31:0]     ImemInstruction,
   output logic [31:0]     IFID_Instruction,
   output logic [PC_W-1:0] IFID_PCPlus4,
   output logic            IFID_Valid,
   output logic            Halted,
   output logic [31:0]     FetchCount
);

   logic [PC_W-1:0] pc_q;
   fetch_state_e    state_q;
   ifid_t           ifid_q;
   logic            halted_q;
   logic [31:0]     count_q;

   logic [PC_W-1:0] pc_nxt;
   fetch_state_e    state_nxt;
   logic            fetch;
   logic            squash;
   logic            drop;

   pc_next_select #(
      .IMEM_WORDS (IMEM_WORDS)
   ) u_pc_next_select (
      .pc            (pc_q),
      .state         (state_q),
      .stall         (Stall),
      .branch_taken  (BranchTaken),
      .branch_target (BranchTarget),
      .jump          (Jump),
      .jump_target   (JumpTarget),
      .pc_nxt_c      (pc_nxt),
      .state_nxt_c   (state_nxt),
      .fetch_c       (fetch),
      .squash_c      (squash),
      .drop_c        (drop)
   );

   // PC, state, halt flag and IF/ID register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_q     <= RESET_PC;
         state_q  <= BOOT;
         halted_q <= 1'b0;
         ifid_q   <= '{instruction: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
      end else begin
         pc_q     <= pc_nxt;
         state_q  <= state_nxt;
         halted_q <= (state_nxt == HALT);
         if (squash)
            ifid_q <= '{instruction: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
         else if (fetch)
            ifid_q <= '{instruction: ImemInstruction, pc_plus4: pc_q + PC_W'(4), valid: 1'b1};
         else if (drop)
            ifid_q.valid <= 1'b0;
      end
   end

   // Saturating count of valid IF/ID loads
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)                      count_q <= '0;
      else if (fetch && count_q != '1) count_q <= count_q + 32'(1);
   end

   assign ImemAddress      = pc_q;
   assign IFID_Instruction = ifid_q.instruction;
   assign IFID_PCPlus4     = ifid_q.pc_plus4;
   assign IFID_Valid       = ifid_q.valid;
   assign Halted           = halted_q;
   assign FetchCount       = count_q;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the MIPS datapath. Owns the program counter, drives the address of the combinational 128-word instruction memory, and loads the IF/ID pipeline register. Handles stall, branch/jump redirect with wrong-path squash, and end-of-memory halt, so the rest of the pipeline sees a clean valid-tagged instruction stream.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset; word aligned.
- IMEM_WORDS, 128: instruction memory depth in words; the word index is ImemAddress[8:2].
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset; one clock domain only.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- BranchTaken  in  1  resolved taken branch: redirect to BranchTarget.
- BranchTarget  in  32  branch destination byte address.
- Jump  in  1  jump: redirect to JumpTarget.
- JumpTarget  in  32  jump destination byte address.
- ImemAddress  out  32  byte address to instruction memory; equals PC.
- ImemInstruction  in  32  combinational read data from instruction memory.
- IFID_Instruction  out  32  latched instruction.
- IFID_PCPlus4  out  32  PC of the latched instruction plus 4.
- IFID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- Halted  out  1  high while in HALT.
- FetchCount  out  32  number of valid IF/ID loads; saturating.

## Operation
- States:
  - BOOT: first edge after Reset deasserts. No IF/ID load. Go to RUN.
  - RUN: normal fetching.
  - HALT: PC held, IFID_Valid=0.
- Reset values: PC=RESET_PC, state=BOOT, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, Halted=0, FetchCount=0.
- Redirect = BranchTaken | Jump. When both are high, BranchTaken wins.
  - Target low two bits are forced to 0.
- Per-edge priority in RUN:
  - Redirect: PC<=target; IFID_Valid<=0, which squashes the wrong-path fetch. IFID_Instruction and IFID_PCPlus4 are loaded with 0.
  - else Stall: PC, IFID_* and FetchCount hold.
  - else: IF/ID<=ImemInstruction and PC+4; IFID_Valid<=1; FetchCount+=1, saturating at 32'hFFFF_FFFF.
    - PC<=PC+4 if PC[31:2] != IMEM_WORDS-1.
    - Otherwise (last word): PC holds and the state goes to HALT. The last instruction is still latched valid; no wrap to word 0.
- HALT:
  - Redirect: PC<=target, IFID_Valid<=0, go to RUN. This covers a branch in the final instructions resolving late.
  - Stall is ignored.
  - Otherwise IFID_Valid<=0 every cycle.
- BOOT ignores Stall and Redirect.
- PC+4 arithmetic is 32-bit modulo.
- Only PC[8:2] addresses memory. Targets beyond IMEM_WORDS alias inside memory, but the halt check uses the full PC[31:2].

## Timing
- ImemAddress is combinational from the PC register, with no gating.
- Fetch latency: the instruction at PC appears on IFID_* one edge after PC is presented.
- Redirect latency: a redirect sampled at edge N puts the target on ImemAddress after N. The target instruction is valid in IF/ID after N+1. Exactly one bubble is inserted.
- Stall and BranchTaken are sampled at the same edge: the redirect executes and the stall is dropped.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), including during HALT and during Stall.
- Reset deassertion is followed by one BOOT cycle. The first valid IF/ID appears after the second edge.

## Structure
- Package fetch_pkg holds:
  - the state enum {BOOT, RUN, HALT};
  - NOP_INSTR=32'h0000_0000;
  - the default RESET_PC;
  - the width constants for PC and word index.
- Sub-module pc_next_select: combinational next-PC and next-state logic, with inputs PC, state, Stall, BranchTaken, Jump and the targets. The top module keeps only the registers and the saturating counter.
- Expected size: 150–250 lines total.

## Test plan
- Reset release, memory with word i = i*3, no stall:
  - IFID_Valid=0 for the first two edges.
  - Then IFID_Instruction=0, 3, 6 on successive cycles; IFID_PCPlus4=4, 8, 12.
  - FetchCount increments by 1 per cycle.
- Stall held for 3 cycles at PC=0x10: ImemAddress stays 0x10; IFID_* and FetchCount are unchanged; fetch resumes with instruction 12.
- BranchTaken with BranchTarget=0x42 and Stall high in the same cycle:
  - next ImemAddress=0x40;
  - one IFID_Valid=0 bubble;
  - then IFID_Instruction=48.
- BranchTaken and Jump together (targets 0x20 and 0x60): PC becomes 0x20.
- Sequential run to PC=0x1FC:
  - instruction 381 is latched valid;
  - Halted=1 and PC stays 0x1FC;
  - IFID_Valid stays 0.
  - Jump to 0x0 then resumes RUN with one bubble.
- Reset pulsed low mid-run at PC=0x30: all outputs are at reset values asynchronously, before the next edge; BOOT follows release.
